alu_sequencer: RTL and testbench

- Small stored-program sequencer for the 6-bit CPU.
- Holds a 16-entry instruction memory and a 4-entry register file.
- Runs a fetch/execute FSM that drives the shared 6-bit ALU (OP=0 add, OP=1 subtract) and writes ALU results back.
- Sits between the program loader / testbench and the existing ALU datapath; the ALU stays external and purely combinational.

---
 rtl/alu_sequencer.sv | 176 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//   Stored-program sequencer for the 6-bit CPU. Holds a 16-word instruction
//   memory and a 4-entry register file, and runs a FETCH/EXEC loop that drives
//   the external combinational ALU and writes its result back.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   prog_we     instruction memory write enable (honoured in IDLE/DONE only)
//   prog_addr   instruction memory write address
//   prog_data   instruction word to write
//   start       begin execution at pc=0 (honoured in IDLE/DONE only)
//   A, B, OP    ALU operands / operation (0 add, 1 subtract)
//   alu_result  ALU result, combinational in the same cycle
//   alu_zf      ALU zero flag, combinational in the same cycle
//   busy        high in FETCH and EXEC
//   done        high in DONE
//   zflag       registered zero flag from the last ADD/SUB
//   pc          current program counter
//   dbg_sel     register file debug read select
//   dbg_data    register file debug read data (combinational)
//
// Instruction word [9:0]
//   00 ADD rd[7:6], rs[5:4]   rd <= rd + rs
//   01 SUB rd[7:6], rs[5:4]   rd <= rd - rs
//   10 LDI rd[7:6], imm[5:0]  rd <= imm
//   11 CTRL: [7]=1 HALT, [7]=0 JZ target[3:0]
// -----------------------------------------------------------------------------
module alu_sequencer #(
  parameter int DATA_W  = 6,
  parameter int PC_W    = 4,
  parameter int INSTR_W = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               start,
  output logic [DATA_W-1:0]  A,
  output logic [DATA_W-1:0]  B,
  output logic               OP,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic               alu_zf,
  output logic               busy,
  output logic               done,
  output logic               zflag,
  output logic [PC_W-1:0]    pc,
  input  logic [1:0]         dbg_sel,
  output logic [DATA_W-1:0]  dbg_data
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_DONE} state_t;
  typedef enum logic [1:0] {OPC_ADD, OPC_SUB, OPC_LDI, OPC_CTRL} opcode_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [INSTR_W-1:0]  r_imem [2**PC_W];
  logic [INSTR_W-1:0]  r_ir;
  logic [DATA_W-1:0]   r_regs [4];
  logic [PC_W-1:0]     r_pc;
  logic                r_zflag;

  // Instruction field decode from the latched instruction register.
  opcode_t             w_opcode;
  logic [1:0]          w_rd;
  logic [1:0]          w_rs;
  logic [DATA_W-1:0]   w_imm;
  logic [PC_W-1:0]     w_target;
  logic                w_halt;
  logic                w_idle_like;

  assign w_opcode    = opcode_t'(r_ir[9:8]);
  assign w_rd        = r_ir[7:6];
  assign w_rs        = r_ir[5:4];
  assign w_imm       = r_ir[DATA_W-1:0];
  assign w_target    = r_ir[PC_W-1:0];
  assign w_halt      = (w_opcode == OPC_CTRL) && r_ir[7];
  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);

  assign pc       = r_pc;
  assign zflag    = r_zflag;
  assign dbg_data = r_regs[dbg_sel];

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: if (start) w_next_state = S_FETCH;
      S_FETCH:        w_next_state = S_EXEC;
      S_EXEC:         w_next_state = w_halt ? S_DONE : S_FETCH;
      default:        w_next_state = S_IDLE;
    endcase
  end

  // Outputs decoded from state. busy falls asynchronously with reset because
  // the state register resets asynchronously.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    A    = '0;
    B    = '0;
    OP   = 1'b0;
    unique case (r_state)
      S_FETCH: busy = 1'b1;
      S_EXEC: begin
        busy = 1'b1;
        if (w_opcode == OPC_ADD || w_opcode == OPC_SUB) begin
          A  = r_regs[w_rd];
          B  = r_regs[w_rs];
          OP = r_ir[8];
        end
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Program counter, zero flag, instruction register and register file.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc    <= '0;
      r_zflag <= 1'b0;
      r_ir    <= '0;
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_pc    <= '0;
            r_zflag <= 1'b0;
          end
        end
        S_FETCH: r_ir <= r_imem[r_pc];
        S_EXEC: begin
          unique case (w_opcode)
            OPC_ADD, OPC_SUB: begin
              r_regs[w_rd] <= alu_result;
              r_zflag      <= alu_zf;
              r_pc         <= r_pc + 1'b1;
            end
            OPC_LDI: begin
              r_regs[w_rd] <= w_imm;
              r_pc         <= r_pc + 1'b1;
            end
            OPC_CTRL: begin
              // HALT holds pc; JZ branches on the registered flag.
              if (!r_ir[7]) r_pc <= r_zflag ? w_target : r_pc + 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Instruction memory write port.
  // NOTE: the memory has no reset so a loaded program survives a reset pulse;
  // this also lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (prog_we && w_idle_like) r_imem[prog_addr] <= prog_data;
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
//   Directed bench for alu_sequencer. Models the external ALU, loads short
//   programs, and compares DUT outputs against expected values queued in a
//   scoreboard before each test is launched.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;

  localparam int DATA_W  = 6;
  localparam int PC_W    = 4;
  localparam int INSTR_W = 10;

  logic               clk = 1'b0;
  logic               reset;
  logic               prog_we;
  logic [PC_W-1:0]    prog_addr;
  logic [INSTR_W-1:0] prog_data;
  logic               start;
  logic [DATA_W-1:0]  A, B;
  logic               OP;
  logic [DATA_W-1:0]  alu_result;
  logic               alu_zf;
  logic               busy, done, zflag;
  logic [PC_W-1:0]    pc;
  logic [1:0]         dbg_sel;
  logic [DATA_W-1:0]  dbg_data;

  always #5 clk = ~clk;

  // External combinational ALU.
  assign alu_result = OP ? (A - B) : (A + B);
  assign alu_zf     = (alu_result == '0);

  alu_sequencer #(.DATA_W(DATA_W), .PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .A(A), .B(B), .OP(OP),
    .alu_result(alu_result), .alu_zf(alu_zf), .busy(busy), .done(done),
    .zflag(zflag), .pc(pc), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  // Scoreboard of expected values, consumed in order.
  typedef struct {
    string       tag;
    logic [15:0] exp;
  } sb_t;
  sb_t sb_q[$];
  int  n_assert = 0;
  int  n_fail   = 0;

  task automatic expect_val(input string tag, input int v);
    sb_t e;
    e.tag = tag;
    e.exp = 16'(v);
    sb_q.push_back(e);
  endtask

  task automatic check(input logic [15:0] obs);
    sb_t e;
    n_assert++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0d required <none>", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %0d required %0d", e.tag, obs, e.exp);
      end
    end
  endtask

  // Instruction encoders.
  function automatic logic [9:0] f_ldi(input logic [1:0] rd, input logic [5:0] imm);
    return {2'b10, rd, imm};
  endfunction
  function automatic logic [9:0] f_alu(input logic sub, input logic [1:0] rd, input logic [1:0] rs);
    return {1'b0, sub, rd, rs, 4'b0000};
  endfunction
  function automatic logic [9:0] f_jz(input logic [3:0] t);
    return {2'b11, 4'b0000, t};
  endfunction
  function automatic logic [9:0] f_halt();
    return {2'b11, 1'b1, 7'b0};
  endfunction

  // Write one word; called while the sequencer is in IDLE or DONE.
  task automatic write_imem(input logic [3:0] addr, input logic [9:0] data);
    prog_we   = 1'b1;
    prog_addr = addr;
    prog_data = data;
    @(posedge clk); #1;
    prog_we   = 1'b0;
  endtask

  task automatic load_add_prog();
    write_imem(4'd0, f_ldi(2'd0, 6'd3));
    write_imem(4'd1, f_ldi(2'd1, 6'd4));
    write_imem(4'd2, f_alu(1'b0, 2'd0, 2'd1));
    write_imem(4'd3, f_halt());
  endtask

  // Pulse start and count edges (start-sampling edge is edge 1) until done,
  // bounded by a cycle budget.
  task automatic run_prog(output int n_edges);
    start   = 1'b1;
    n_edges = 0;
    do begin
      @(posedge clk); #1;
      start = 1'b0;
      n_edges++;
    end while (!done && n_edges < 40);
  endtask

  task automatic read_reg(input logic [1:0] sel);
    dbg_sel = sel;
    #1;
    check(16'(dbg_data));
  endtask

  int n_edges;

  initial begin
    reset = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    start = 1'b0; dbg_sel = '0;

    // ---- Reset state ----
    repeat (3) @(posedge clk);
    #1;
    expect_val("rst_busy", 0); expect_val("rst_done", 0); expect_val("rst_pc", 0);
    expect_val("rst_zflag", 0); expect_val("rst_A", 0); expect_val("rst_B", 0);
    expect_val("rst_OP", 0);
    for (int i = 0; i < 4; i++) expect_val($sformatf("rst_r%0d", i), 0);
    check(16'(busy)); check(16'(done)); check(16'(pc)); check(16'(zflag));
    check(16'(A)); check(16'(B)); check(16'(OP));
    for (int i = 0; i < 4; i++) read_reg(2'(i));
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // ---- Basic add: done on the 9th edge, ADD operands visible in EXEC ----
    load_add_prog();
    expect_val("add_A", 3); expect_val("add_B", 4); expect_val("add_OP", 0);
    expect_val("add_done_e8", 0); expect_val("add_done_e9", 1);
    expect_val("add_r0", 7); expect_val("add_zflag", 0); expect_val("add_pc", 3);
    start = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (e == 6) begin check(16'(A)); check(16'(B)); check(16'(OP)); end
      if (e == 8) check(16'(done));
      if (e == 9) check(16'(done));
    end
    read_reg(2'd0); check(16'(zflag)); check(16'(pc));

    // ---- Subtract to zero, taken branch over LDI r2 ----
    write_imem(4'd0, f_ldi(2'd0, 6'd5));
    write_imem(4'd1, f_ldi(2'd1, 6'd5));
    write_imem(4'd2, f_alu(1'b1, 2'd0, 2'd1));
    write_imem(4'd3, f_jz(4'd5));
    write_imem(4'd4, f_ldi(2'd2, 6'd63));
    write_imem(4'd5, f_halt());
    expect_val("jz_edges", 11); expect_val("jz_r0", 0); expect_val("jz_zflag", 1);
    expect_val("jz_r2", 0); expect_val("jz_pc", 5);
    run_prog(n_edges);
    check(16'(n_edges)); read_reg(2'd0); check(16'(zflag)); read_reg(2'd2); check(16'(pc));

    // ---- Wrap-around 63+1 -> 0, then 0-1 -> 63 ----
    write_imem(4'd0, f_ldi(2'd0, 6'd63));
    write_imem(4'd1, f_ldi(2'd1, 6'd1));
    write_imem(4'd2, f_alu(1'b0, 2'd0, 2'd1));
    write_imem(4'd3, f_halt());
    expect_val("wrap_edges", 9); expect_val("wrap_r0", 0); expect_val("wrap_zflag", 1);
    run_prog(n_edges);
    check(16'(n_edges)); read_reg(2'd0); check(16'(zflag));

    write_imem(4'd0, f_alu(1'b1, 2'd0, 2'd1));
    write_imem(4'd1, f_halt());
    expect_val("sub_A", 0); expect_val("sub_B", 1); expect_val("sub_OP", 1);
    expect_val("sub_done", 1); expect_val("sub_r0", 63); expect_val("sub_zflag", 0);
    expect_val("sub_r1", 1);
    start = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (e == 2) begin check(16'(A)); check(16'(B)); check(16'(OP)); end
    end
    check(16'(done)); read_reg(2'd0); check(16'(zflag)); read_reg(2'd1);

    // ---- Reset during EXEC of instruction 2, then rerun ----
    load_add_prog();
    expect_val("mid_busy_pre", 1); expect_val("mid_busy", 0); expect_val("mid_done", 0);
    expect_val("mid_pc", 0);
    for (int i = 0; i < 4; i++) expect_val($sformatf("mid_r%0d", i), 0);
    expect_val("rerun_edges", 9); expect_val("rerun_r0", 7); expect_val("rerun_r1", 4);
    expect_val("rerun_pc", 3);
    start = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    check(16'(busy));
    reset = 1'b0;
    #1;
    check(16'(busy)); check(16'(done)); check(16'(pc));
    for (int i = 0; i < 4; i++) read_reg(2'(i));
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    run_prog(n_edges);
    check(16'(n_edges)); read_reg(2'd0); read_reg(2'd1); check(16'(pc));

    // ---- prog_we and start while busy are ignored ----
    begin
      int pc_seq[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 3};
      for (int e = 0; e < 9; e++) expect_val($sformatf("busy_pc_e%0d", e + 1), pc_seq[e]);
    end
    expect_val("busy_done", 1); expect_val("busy_r0", 7); expect_val("busy_r3", 0);
    start = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk); #1;
      if (e >= 2 && e <= 5) begin
        start     = 1'b1;
        prog_we   = 1'b1;
        prog_addr = 4'd3;
        prog_data = f_ldi(2'd3, 6'd9);
      end else begin
        start   = 1'b0;
        prog_we = 1'b0;
      end
      check(16'(pc));
    end
    check(16'(done)); read_reg(2'd0); read_reg(2'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
